// File: rtl/tcam_pkg.sv
// Shared constants, types and helpers for the TCAM rule writer.
// Geometry: 32 rules, 28-bit keys split into 4 blocks of 7 bits.
package tcam_pkg;

    localparam int NUM_RULES  = 32;
    localparam int KEY_W      = 28;
    localparam int SLICE_W    = 7;
    localparam int NUM_BLOCKS = 4;
    localparam int ROW_ADDR_W = 9;
    localparam int SWEEP_LEN  = 512;
    localparam int IDX_W      = 6;
    localparam int ID_W       = 5;
    localparam int LANES      = 4;

    localparam logic [ROW_ADDR_W-1:0] LAST_ROW =
        ROW_ADDR_W'(SWEEP_LEN - 1);

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        SWEEP
    } state_t;

    typedef struct packed {
        logic [KEY_W-1:0] value;
        logic [KEY_W-1:0] care;
        logic             valid;
    } rule_t;

    // Block 0 owns the most significant key slice.
    function automatic logic [SLICE_W-1:0] key_slice(
        input logic [KEY_W-1:0] key,
        input logic [1:0]       blk
    );
        logic [KEY_W-1:0] sh;
        sh = key >> (SLICE_W * (NUM_BLOCKS - 1 - int'(blk)));
        return sh[SLICE_W-1:0];
    endfunction

endpackage

// File: rtl/tcam_row_gen.sv
// Builds one SRAM row word of the TCAM from the shadow rule table.
// Ports: row (9-bit sweep row), rules (table), row_word (32-bit data).
module tcam_row_gen
    import tcam_pkg::*;
(
    input  logic [ROW_ADDR_W-1:0] row,
    input  rule_t                 rules [NUM_RULES],
    output logic [NUM_RULES-1:0]  row_word
);

    logic [1:0]         blk;
    logic [SLICE_W-1:0] idx;

    assign blk = row[ROW_ADDR_W-1 -: 2];
    assign idx = row[SLICE_W-1:0];

    // A rule hits this row when the row index agrees with its
    // value slice on every cared bit of this block.
    always_comb begin
        row_word = '0;
        for (int k = 0; k < NUM_RULES; k++) begin
            row_word[k] = rules[k].valid &
                (((idx ^ key_slice(rules[k].value, blk)) &
                  key_slice(rules[k].care, blk)) == '0);
        end
    end

endmodule

// File: rtl/tcam_rule_writer.sv
// Control stage for the SRAM TCAM: rule table, rewrite sweeps, search.
// Ports: cmd_* rule commands, srch_*/rslt_* search path, tcam_* SRAM port.
module tcam_rule_writer
    import tcam_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_op_i,
    input  logic [ID_W-1:0]       cmd_id_i,
    input  logic [KEY_W-1:0]      cmd_value_i,
    input  logic [KEY_W-1:0]      cmd_care_i,
    input  logic                  srch_valid_i,
    output logic                  srch_ready_o,
    input  logic [KEY_W-1:0]      srch_key_i,
    output logic                  rslt_valid_o,
    output logic [IDX_W-1:0]      rslt_idx_o,
    output logic                  upd_done_o,
    output logic                  tcam_csb_o,
    output logic                  tcam_web_o,
    output logic [LANES-1:0]      tcam_wmask_o,
    output logic [KEY_W-1:0]      tcam_addr_o,
    output logic [NUM_RULES-1:0]  tcam_wdata_o,
    input  logic [IDX_W-1:0]      tcam_rdata_i
);

    state_t                state;
    logic [ROW_ADDR_W-1:0] row;
    rule_t                 rules [NUM_RULES];
    logic [1:0]            lane;

    logic                  wr_csb;
    logic                  wr_web;
    logic [LANES-1:0]      wr_wmask;
    logic [ROW_ADDR_W-1:0] wr_addr;
    logic [NUM_RULES-1:0]  wr_wdata;

    logic                  srch_go;
    logic                  srch_pend;
    logic                  last_row;
    logic [NUM_RULES-1:0]  row_word;

    tcam_row_gen u_row_gen (
        .row      (row),
        .rules    (rules),
        .row_word (row_word)
    );

    // cmd_ready_o is high exactly while idle, so searches can
    // only reach the port between sweeps.
    assign srch_ready_o = cmd_ready_o & ~cmd_valid_i;
    assign srch_go      = srch_valid_i & srch_ready_o;

    assign tcam_csb_o   = wr_csb & ~srch_go;
    assign tcam_web_o   = wr_web;
    assign tcam_wmask_o = wr_wmask;
    assign tcam_wdata_o = wr_wdata;
    assign tcam_addr_o  = srch_go ? srch_key_i :
        {{(KEY_W-ROW_ADDR_W){1'b0}}, wr_addr};

    // The sweep ends once the last row has been on the port.
    assign last_row = ~wr_csb & (wr_addr == LAST_ROW);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= INIT;
            row          <= '0;
            lane         <= '0;
            for (int i = 0; i < NUM_RULES; i++) begin
                rules[i] <= '0;
            end
            wr_csb       <= 1'b1;
            wr_web       <= 1'b1;
            wr_wmask     <= '0;
            wr_addr      <= '0;
            wr_wdata     <= '0;
            cmd_ready_o  <= 1'b0;
            upd_done_o   <= 1'b0;
            srch_pend    <= 1'b0;
            rslt_valid_o <= 1'b0;
            rslt_idx_o   <= '0;
        end else begin
            upd_done_o   <= 1'b0;
            srch_pend    <= srch_go;
            rslt_valid_o <= srch_pend;
            if (srch_pend) begin
                rslt_idx_o <= tcam_rdata_i;
            end

            unique case (state)
                INIT, SWEEP: begin
                    if (last_row) begin
                        state       <= IDLE;
                        cmd_ready_o <= 1'b1;
                        upd_done_o  <= (state == SWEEP);
                        wr_csb      <= 1'b1;
                        wr_web      <= 1'b1;
                        wr_wmask    <= '0;
                        wr_addr     <= '0;
                        wr_wdata    <= '0;
                    end else begin
                        wr_csb  <= 1'b0;
                        wr_web  <= 1'b0;
                        wr_addr <= row;
                        row     <= row + 1'b1;
                        if (state == INIT) begin
                            wr_wmask <= '1;
                            wr_wdata <= '0;
                        end else begin
                            wr_wmask <= LANES'(1) << lane;
                            wr_wdata <= row_word;
                        end
                    end
                end
                IDLE: begin
                    if (cmd_valid_i) begin
                        if (cmd_op_i) begin
                            rules[cmd_id_i] <= '{
                                value: cmd_value_i,
                                care:  cmd_care_i,
                                valid: 1'b1
                            };
                        end else begin
                            rules[cmd_id_i].valid <= 1'b0;
                        end
                        lane        <= cmd_id_i[ID_W-1 -: 2];
                        row         <= '0;
                        state       <= SWEEP;
                        cmd_ready_o <= 1'b0;
                    end
                end
                default: begin
                    state <= INIT;
                    row   <= '0;
                end
            endcase
        end
    end

endmodule
